// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_queue_pkg : shared types for the prefetching fetch stage
// Rev 1.0
// ----------------------------------------------------------------------------
package fetch_queue_pkg;

   typedef logic [31:0] regval_t;

   // Canonical no-op (addi x0, x0, 0) presented to decode when nothing is ready
   localparam regval_t Nop = 32'h0000_0013;

   typedef struct packed {
      regval_t instruction;
      regval_t pc;
   } fetch_entry_t;

   typedef enum logic [0:0] {
      IsActive   = 1'b0,
      IsFlushing = 1'b1
   } fetch_state_e;

   function automatic regval_t pc_step(input regval_t p);
      return p + 32'd4;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i_fetch_to_decode : fetch -> decode link (instruction/pc out, hold/redirect in)
// Rev 1.0
// ----------------------------------------------------------------------------
interface i_fetch_to_decode;
   import fetch_queue_pkg::*;

   regval_t instruction;
   regval_t pc;
   logic    hold;
   logic    is_pc_changing;

   modport fetch_out (
      output instruction,
      output pc,
      input  hold,
      input  is_pc_changing
   );

   modport decode (
      input  instruction,
      input  pc,
      output hold,
      output is_pc_changing
   );

endinterface
`default_nettype wire

// File: rtl/fetch_queue_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_queue_fifo : DEPTH-entry circular buffer of fetch entries with clear
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_queue_fifo
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  wire logic                       clock,
   input  wire logic                       reset_n,
   input  wire logic                       push,
   input  wire fetch_entry_t               push_data,
   input  wire logic                       pop,
   input  wire logic                       clear,
   output logic [$clog2(DEPTH+1)-1:0]      count,
   output fetch_entry_t                    head
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   fetch_entry_t       mem_q [DEPTH];
   fetch_entry_t       mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               do_push;
   logic               do_pop;

   // Pointers wrap explicitly so DEPTH need not be a power of two
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      mem_q <= mem_d;
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_queue : prefetching fetch stage, DEPTH-entry queue, flush on PC change
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter regval_t     RESET_PC        = '0
) (
   input  wire logic           clock,
   input  wire logic           reset_n,
   input  wire logic           has_flushed,
   input  wire logic           data_valid,
   input  wire regval_t        pc,
   input  wire regval_t        data,
   output logic                address_enable,
   output regval_t             address,
   output regval_t             next_pc,
   i_fetch_to_decode.fetch_out outi
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

   fetch_state_e     state_q, state_d;
   logic [OUT_W-1:0] outstanding_q, outstanding_d;
   logic [OUT_W-1:0] drop_count_q, drop_count_d;
   regval_t          resp_pc_q, resp_pc_d;
   regval_t          instr_q, instr_d;
   regval_t          out_pc_q, out_pc_d;

   logic [CNT_W-1:0] fifo_count;
   fetch_entry_t     fifo_head;
   fetch_entry_t     push_entry;
   logic             fifo_push;
   logic             fifo_pop;
   logic             flush;
   logic             issue;
   logic             retire;
   logic [SUM_W-1:0] credit_sum;

   fetch_queue_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .clear     (flush),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IsActive: begin
            if (outi.is_pc_changing) state_d = IsFlushing;
         end
         IsFlushing: begin
            if (!outi.is_pc_changing && has_flushed && (drop_count_q == '0)) state_d = IsActive;
         end
         default: state_d = IsActive;
      endcase
   end

   // Reads are only issued when queue space is reserved for every response
   always_comb begin
      flush          = outi.is_pc_changing;
      credit_sum     = SUM_W'(fifo_count) + SUM_W'(outstanding_q);
      issue          = (state_d == IsActive)
                    && (outstanding_q < OUT_W'(MAX_OUTSTANDING))
                    && (credit_sum < SUM_W'(DEPTH));
      address_enable = !reset_n || issue;
      address        = reset_n ? pc : RESET_PC;
      if (!reset_n)   next_pc = RESET_PC;
      else if (issue) next_pc = pc_step(pc);
      else            next_pc = pc;
   end

   always_comb begin
      retire        = data_valid && (outstanding_q != '0);
      fifo_push     = data_valid && (drop_count_q == '0) && !flush;
      push_entry    = '{instruction: data, pc: resp_pc_q};
      outstanding_d = outstanding_q;
      if (issue && !retire)      outstanding_d = outstanding_q + OUT_W'(1);
      else if (!issue && retire) outstanding_d = outstanding_q - OUT_W'(1);

      // A response retiring in the flush cycle is already gone, so it is not dropped later
      drop_count_d = drop_count_q;
      if (flush)                                    drop_count_d = outstanding_q - OUT_W'(retire);
      else if (data_valid && drop_count_q != '0)    drop_count_d = drop_count_q - OUT_W'(1);

      resp_pc_d = resp_pc_q;
      if (state_q == IsFlushing && state_d == IsActive) resp_pc_d = pc;
      else if (fifo_push)                               resp_pc_d = pc_step(resp_pc_q);
   end

   always_comb begin
      fifo_pop = !outi.hold && !flush && (fifo_count != '0);
      instr_d  = instr_q;
      out_pc_d = out_pc_q;
      if (!outi.hold) begin
         if (fifo_pop) begin
            instr_d  = fifo_head.instruction;
            out_pc_d = fifo_head.pc;
         end else begin
            instr_d  = Nop;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q       <= IsActive;
         outstanding_q <= '0;
         drop_count_q  <= '0;
         resp_pc_q     <= RESET_PC;
         instr_q       <= Nop;
         out_pc_q      <= '0;
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_d;
         drop_count_q  <= drop_count_d;
         resp_pc_q     <= resp_pc_d;
         instr_q       <= instr_d;
         out_pc_q      <= out_pc_d;
      end
   end

   assign outi.instruction = instr_q;
   assign outi.pc          = out_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_queue : in-order memory model, external PC register, stream scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int unsigned DEPTH    = 4;
   localparam int unsigned MAXO     = 2;
   localparam regval_t     RESET_PC = 32'h0;

   typedef struct {
      regval_t addr;
      int      ready;
   } req_t;

   logic    clk = 1'b1;
   logic    reset_n = 1'b0;
   logic    has_flushed = 1'b0;
   logic    data_valid = 1'b0;
   regval_t pc = 32'h100;
   regval_t data = '0;
   logic    address_enable;
   regval_t address;
   regval_t next_pc;

   i_fetch_to_decode outi ();

   fetch_queue #(
      .DEPTH           (DEPTH),
      .MAX_OUTSTANDING (MAXO),
      .RESET_PC        (RESET_PC)
   ) dut (
      .clock          (clk),
      .reset_n        (reset_n),
      .has_flushed    (has_flushed),
      .data_valid     (data_valid),
      .pc             (pc),
      .data           (data),
      .address_enable (address_enable),
      .address        (address),
      .next_pc        (next_pc),
      .outi           (outi)
   );

   always #5 clk = ~clk;

   int           n_cmp = 0;
   int           n_bad = 0;
   int           cyc = 0;
   int           n_deliv = 0;
   int           first_issue_cyc = -1;
   int           first_deliv_cyc = -1;
   int           lat_min = 1;
   int           lat_max = 1;
   logic         p_rstn = 1'b0, p_hold = 1'b0, p_ipc = 1'b0, ae_n = 1'b0, dv_n = 1'b0;
   regval_t      addr_n = '0, npc_n = '0, tgt_n = '0;
   regval_t      redirect_pc = '0;
   logic         want_first = 1'b0;
   regval_t      want_addr = '0;
   regval_t      iss_q [$];
   req_t         mem_q [$];
   fetch_entry_t exp_q [$];
   regval_t      exp_next = '0;

   function automatic regval_t mem_word(input regval_t a);
      return a ^ 32'hC0DE_F00C;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference stream: decode must see consecutive words from the latest fetch target
   task automatic sb_fill();
      while (exp_q.size() < 16) begin
         exp_q.push_back('{instruction: mem_word(exp_next), pc: exp_next});
         exp_next = exp_next + 32'd4;
      end
   endtask

   task automatic sb_restart(input regval_t base);
      exp_q.delete();
      exp_next = base;
      sb_fill();
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic redirect(input regval_t tgt);
      outi.is_pc_changing = 1'b1;
      redirect_pc         = tgt;
      cycles(1);
      outi.is_pc_changing = 1'b0;
   endtask

   task automatic wait_resume(input string name);
      int k;
      k = 0;
      while (want_first && k < 60) begin
         cycles(1);
         k++;
      end
      check(name, 32'(want_first), 32'd0);
   endtask

   // Monitor: samples mid-cycle, checks deliveries and captures values for the models
   initial begin
      forever begin : mon
         fetch_entry_t e;
         @(negedge clk);
         cyc++;
         if (p_rstn && !p_hold && !p_ipc && outi.instruction !== Nop) begin
            n_deliv++;
            if (first_deliv_cyc < 0) first_deliv_cyc = cyc;
            sb_fill();
            e = exp_q.pop_front();
            check("decode_pc", outi.pc, e.pc);
            check("decode_instr", outi.instruction, e.instruction);
            sb_fill();
         end
         if (!reset_n) begin
            sb_restart(RESET_PC);
            iss_q.delete();
            first_issue_cyc = -1;
            first_deliv_cyc = -1;
            want_first      = 1'b0;
         end else if (outi.is_pc_changing) begin
            sb_restart(redirect_pc);
            want_first = 1'b1;
            want_addr  = redirect_pc;
         end else if (address_enable) begin
            if (want_first) begin
               check("first_issue_after_flush", address, want_addr);
               want_first = 1'b0;
            end
            iss_q.push_back(address);
            if (first_issue_cyc < 0) first_issue_cyc = cyc;
         end
         if (reset_n) check("outstanding_bound", 32'(mem_q.size() <= MAXO), 32'd1);
         p_rstn = reset_n;
         p_hold = outi.hold;
         p_ipc  = outi.is_pc_changing;
         ae_n   = address_enable;
         addr_n = address;
         npc_n  = next_pc;
         dv_n   = data_valid;
         tgt_n  = redirect_pc;
      end
   end

   // In-order memory with random latency, plus the external PC register
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!p_rstn) begin
            mem_q.delete();
            data_valid = 1'b0;
            pc         = npc_n;
         end else begin
            if (dv_n && mem_q.size() > 0) mem_q.delete(0);
            if (ae_n) mem_q.push_back('{addr: addr_n, ready: cyc + int'($urandom_range(lat_max, lat_min))});
            pc = p_ipc ? tgt_n : npc_n;
            if (mem_q.size() > 0 && mem_q[0].ready <= cyc + 1) begin
               data_valid = 1'b1;
               data       = mem_word(mem_q[0].addr);
            end else begin
               data_valid = 1'b0;
               data       = $urandom;
            end
         end
      end
   end

   initial begin
      int d0;
      int n0;
      logic [31:0] r;
      outi.hold           = 1'b0;
      outi.is_pc_changing = 1'b0;
      #2;
      check("rst_addr_en", 32'(address_enable), 32'd1);
      check("rst_address", address, RESET_PC);
      check("rst_next_pc", next_pc, RESET_PC);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("rst_out_instr", outi.instruction, Nop);
      check("rst_out_pc", outi.pc, 32'h0);

      // Streaming with single-cycle memory
      cycles(9);
      check("stream_latency", 32'(first_deliv_cyc - first_issue_cyc), 32'd3);
      check("stream_issue_rate", 32'(iss_q.size() >= 9), 32'd1);
      for (int i = 0; i < 6; i++)
         check("stream_addr", (iss_q.size() > i) ? iss_q[i] : 32'hDEAD_DEAD, 32'(4 * i));

      // Backpressure fills queue plus outstanding up to DEPTH
      outi.hold = 1'b1;
      cycles(10);
      @(negedge clk);
      check("bp_issue_stopped", 32'(address_enable), 32'd0);
      check("bp_inflight", 32'(mem_q.size()), 32'd0);
      @(posedge clk);
      #1;
      d0        = n_deliv;
      outi.hold = 1'b0;
      cycles(5);
      @(negedge clk);
      check("bp_drain_count", 32'(n_deliv - d0 >= 4), 32'd1);

      // Flush with two reads in flight; has_flushed arrives two cycles later
      @(posedge clk);
      #1;
      lat_min = 3;
      lat_max = 3;
      cycles(10);
      has_flushed = 1'b0;
      redirect(32'h200);
      cycles(1);
      has_flushed = 1'b1;
      wait_resume("flush_resume");
      d0 = n_deliv;
      cycles(15);
      check("flush_progress", 32'(n_deliv > d0), 32'd1);

      // Flush coinciding with a response (continuous single-cycle stream)
      lat_min = 1;
      lat_max = 1;
      cycles(8);
      redirect(32'h300);
      wait_resume("flush_dv_resume");
      cycles(8);

      // Address wrap-around
      n0 = iss_q.size();
      redirect(32'hFFFF_FFFC);
      wait_resume("wrap_resume");
      cycles(4);
      check("wrap_addr0", (iss_q.size() > n0) ? iss_q[n0] : 32'hDEAD_DEAD, 32'hFFFF_FFFC);
      check("wrap_addr1", (iss_q.size() > n0 + 1) ? iss_q[n0 + 1] : 32'hDEAD_DEAD, 32'h0);

      // Randomized hold, latency, redirects and drain signalling
      lat_min = 1;
      lat_max = 4;
      for (int i = 0; i < 600; i++) begin
         outi.hold   = ($urandom % 100) < 30;
         has_flushed = ($urandom % 4) != 0;
         if (($urandom % 40) == 0) begin
            r                   = $urandom;
            redirect_pc         = r & 32'hFFFF_FFFC;
            outi.is_pc_changing = 1'b1;
         end else begin
            outi.is_pc_changing = 1'b0;
         end
         cycles(1);
      end

      outi.hold           = 1'b0;
      outi.is_pc_changing = 1'b0;
      has_flushed         = 1'b1;
      d0 = n_deliv;
      for (int k = 0; k < 200 && n_deliv < d0 + 10; k++) cycles(1);
      check("final_progress", 32'(n_deliv >= d0 + 10), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
